// File: rtl/sumator_pkg.sv
// rtl/sumator_pkg.sv - shared state encoding and default sizes for the multi-cycle adder
package sumator_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sumator_cuvant.sv
// rtl/sumator_cuvant.sv - combinational WIDTH-bit adder exposing carry-in to the MSB for overflow
module sumator_cuvant #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             carry_msb
);

  logic [WIDTH-1:0] low;

  // Add the low WIDTH-1 bits separately so the carry into the MSB is visible.
  assign low       = {1'b0, a[WIDTH-2:0]} + {1'b0, b[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin};
  assign carry_msb = low[WIDTH-1];
  assign s         = {a[WIDTH-1] ^ b[WIDTH-1] ^ carry_msb, low[WIDTH-2:0]};
  assign cout      = (a[WIDTH-1] & b[WIDTH-1]) | (carry_msb & (a[WIDTH-1] ^ b[WIDTH-1]));

endmodule

// File: rtl/sumator_multicuvant_ctrl.sv
// rtl/sumator_multicuvant_ctrl.sv - wide adder built from one shared word adder, one word per cycle
module sumator_multicuvant_ctrl
  import sumator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_ADD  = ADD;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]             state;
  logic [WIDTH*WORDS-1:0] a_reg;
  logic [WIDTH*WORDS-1:0] b_reg;
  logic [IDX_W-1:0]       idx;
  logic                   carry;

  logic [WIDTH-1:0] word_a;
  logic [WIDTH-1:0] word_b;
  logic [WIDTH-1:0] word_s;
  logic             word_cout;
  logic             word_cmsb;
  logic             accept;

  assign word_a = a_reg[int'(idx)*WIDTH +: WIDTH];
  assign word_b = b_reg[int'(idx)*WIDTH +: WIDTH];

  sumator_cuvant #(.WIDTH(WIDTH)) u_cuvant (
    .a         (word_a),
    .b         (word_b),
    .cin       (carry),
    .s         (word_s),
    .cout      (word_cout),
    .carry_msb (word_cmsb)
  );

  // A new request is only taken when no words are in flight.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign busy   = (state == ST_ADD);
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_ADD: begin
          sum[int'(idx)*WIDTH +: WIDTH] <= word_s;
          carry <= word_cout;
          if (idx == LAST_IDX) begin
            cout     <= word_cout;
            overflow <= word_cmsb ^ word_cout;
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (accept) begin
            a_reg    <= a;
            b_reg    <= b;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            idx      <= '0;
            carry    <= cin;
            state    <= ST_ADD;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
